// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the LED ripple counter front end: the debounce
// state encoding, default timing constants and a counter-width helper.
// No ports (package).

package counter_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } db_state_t;

  localparam int DIV_DEFAULT       = 25_000_000;
  localparam int DB_CYCLES_DEFAULT = 1_000_000;

  // Width needed to count 0..n-1. A counter is never narrower than one bit,
  // even when n is 1 and there is nothing to count.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a single asynchronous board input. The first
// flop may go metastable; only the second flop's output is used.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops to 0
//   d     - raw asynchronous input
//   q     - synchronised copy of d, two clk edges late

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops so that q only ever changes on
  // a clean clk edge, giving the first flop a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/counter_input_conditioner.sv
// counter_input_conditioner
// Front end of the 8-LED ripple counter. Synchronises and debounces the raw
// slide switch into a clean run level, and divides clk down into a slow,
// evenly spaced one-cycle tick that clocks the counter's first stage.
// Parameters:
//   DIV       - tick period in clk cycles (>= 2)
//   DB_CYCLES - stable synchronised cycles needed to accept a switch change (>= 1)
// Ports:
//   clk     - system clock, all state changes on its rising edge
//   rst_n   - asynchronous active-low reset
//   SW      - raw, bouncing slide switch
//   run     - debounced switch level, 1 = counting enabled
//   tick    - one-cycle pulse every DIV cycles while run is 1
//   sw_rise - one-cycle pulse in the cycle after run goes 0->1
//   sw_fall - one-cycle pulse in the cycle after run goes 1->0

module counter_input_conditioner
  import counter_pkg::*;
#(
  parameter int DIV       = DIV_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SW,
  output logic run,
  output logic tick,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int DB_W  = cnt_width(DB_CYCLES);
  localparam int DIV_W = $clog2(DIV);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic            sw_s;
  db_state_t       state;
  db_state_t       state_next;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_next;
  logic            run_next;
  logic [DIV_W-1:0] div_cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (SW),
    .q     (sw_s)
  );

  // Debounce state register. run and the edge pulses are registered next to
  // the state so that no output ever has a combinational path from SW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STABLE_LO;
      db_cnt  <= '0;
      run     <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      state   <= state_next;
      db_cnt  <= db_cnt_next;
      run     <= run_next;
      sw_rise <= run_next & ~run;
      sw_fall <= ~run_next & run;
    end
  end

  // Next-state logic. A change of sw_s opens a check window; the new level
  // is accepted only after DB_CYCLES further agreeing samples, and any
  // reversal drops straight back to the old stable state so the count
  // always restarts from zero on the next attempt.
  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    case (state)
      STABLE_LO: begin
        if (sw_s) begin
          state_next  = CHK_HI;
          db_cnt_next = '0;
        end
      end
      CHK_HI: begin
        if (!sw_s) begin
          state_next = STABLE_LO;
        end else if (db_cnt == DB_LAST) begin
          state_next = STABLE_HI;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sw_s) begin
          state_next  = CHK_LO;
          db_cnt_next = '0;
        end
      end
      CHK_LO: begin
        if (sw_s) begin
          state_next = STABLE_HI;
        end else if (db_cnt == DB_LAST) begin
          state_next = STABLE_LO;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      default: begin
        state_next  = STABLE_LO;
        db_cnt_next = '0;
      end
    endcase
  end

  // The accepted level is a pure function of the state: it stays high while
  // merely checking a possible fall and stays low while checking a rise.
  always_comb begin
    run_next = (state_next == STABLE_HI) || (state_next == CHK_LO);
  end

  // Prescaler. Decisions use the pre-edge run, so a wrap coinciding with
  // the edge where run falls still produces its final tick, and the counter
  // is held at zero from then on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_input_conditioner.sv
// tb_counter_input_conditioner
// Bench for counter_input_conditioner with DIV=8, DB_CYCLES=4. A reference
// model derives every clock's expected outputs from the behavioural rules
// and queues them; a monitor pops and compares once per cycle. Directed
// scenarios add latency, pulse-width and tick-count checks.

module tb_counter_input_conditioner;

  localparam int DIV = 8;
  localparam int DB  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic SW    = 1'b1;
  logic run;
  logic tick;
  logic sw_rise;
  logic sw_fall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_input_conditioner #(
    .DIV       (DIV),
    .DB_CYCLES (DB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SW      (SW),
    .run     (run),
    .tick    (tick),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    SW = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitRun(input logic level, input int max_edges, output int edges);
    edges = 0;
    while (run !== level && edges < max_edges) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic waitTick(input int max_edges, output int edges);
    edges = 0;
    while (tick !== 1'b1 && edges < max_edges) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Reference model: the switch reaches the debouncer two edges late; run
  // takes a new value once that delayed switch has shown it on DB+1
  // consecutive edges; ticks fall on edges a whole multiple of DIV after
  // the rise, provided run was still high just before that edge.
  logic [3:0] exp_q[$];
  bit         hist[$];
  bit         m_s1;
  bit         m_sws;
  bit         m_run;
  int         edge_idx  = 0;
  int         rise_edge = 0;

  always @(posedge clk) begin
    bit run_new;
    bit t;
    bit r;
    bit f;
    bit all_diff;
    if (!rst_n) begin
      m_s1  = 1'b0;
      m_sws = 1'b0;
      m_run = 1'b0;
      hist.delete();
      exp_q.push_back(4'b0000);
    end else begin
      hist.push_back(m_sws);
      if (hist.size() > DB + 1) void'(hist.pop_front());
      run_new = m_run;
      if (hist.size() == DB + 1) begin
        all_diff = 1'b1;
        foreach (hist[i]) if (hist[i] == m_run) all_diff = 1'b0;
        if (all_diff) begin
          run_new = ~m_run;
          hist.delete();
        end
      end
      t = m_run && (((edge_idx - rise_edge) % DIV) == 0);
      r = run_new && !m_run;
      f = !run_new && m_run;
      if (r) rise_edge = edge_idx;
      m_sws = m_s1;
      m_s1  = SW;
      m_run = run_new;
      exp_q.push_back({run_new, t, r, f});
    end
    edge_idx++;
  end

  // Monitor: one expected entry per clock edge, compared mid-cycle. While
  // reset is asserted every output must read zero.
  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = 4'b0000;
      checkOutput("outputs{run,tick,rise,fall}", {28'd0, run, tick, sw_rise, sw_fall}, {28'd0, e});
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int cnt;
    int last;
    int guard;
    bit seen;
    int seg_len[4];
    seg_len = '{3, 2, 3, 20};

    rst_n = 1'b0;
    SW    = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_run", run, 0);
    checkOutput("reset_tick", tick, 0);
    checkOutput("reset_rise", sw_rise, 0);
    checkOutput("reset_fall", sw_fall, 0);

    rst_n = 1'b1;
    waitRun(1'b1, 40, n);
    checkOutput("rise_latency_edges", n, DB + 3);
    checkOutput("rise_pulse", sw_rise, 1);
    @(posedge clk);
    #1;
    checkOutput("rise_pulse_width", sw_rise, 0);
    waitTick(40, n);
    checkOutput("first_tick_edges", n, DIV - 1);
    @(negedge clk);

    cnt  = 0;
    last = -1;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      if (tick) begin
        if (last >= 0) checkOutput("tick_gap", i - last, DIV);
        last = i;
        cnt++;
      end
    end
    checkOutput("tick_count_96", cnt, 12);

    guard = 0;
    while (((edge_idx + DB + 2 - rise_edge) % DIV) != 0 && guard < 32) begin
      @(negedge clk);
      guard++;
    end
    SW = 1'b0;
    repeat (DB + 3) @(posedge clk);
    #1;
    checkOutput("collision_tick", tick, 1);
    checkOutput("collision_run", run, 0);
    checkOutput("collision_fall", sw_fall, 1);
    @(posedge clk);
    #1;
    checkOutput("collision_fall_width", sw_fall, 0);
    checkOutput("collision_div_cnt", {28'd0, dut.div_cnt}, 0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tick) cnt++;
    end
    checkOutput("no_tick_after_collision", cnt, 0);

    seen = 1'b0;
    for (int s = 0; s < 4; s++) begin
      SW = (s % 2 == 0);
      repeat (seg_len[s]) begin
        @(negedge clk);
        if (run || sw_rise) seen = 1'b1;
      end
    end
    checkOutput("bounce_rejected", seen, 0);

    SW = 1'b1;
    waitRun(1'b1, 40, n);
    checkOutput("rise_latency_again", n, DB + 3);
    repeat (20) @(negedge clk);
    SW = 1'b0;
    waitRun(1'b0, 40, n);
    checkOutput("fall_latency_edges", n, DB + 3);
    checkOutput("fall_pulse", sw_fall, 1);
    @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick) cnt++;
    end
    checkOutput("no_tick_after_fall", cnt, 0);

    SW = 1'b1;
    waitRun(1'b1, 40, n);
    @(negedge clk);
    guard = 0;
    while (((edge_idx - 1 - rise_edge) % DIV) != 5 && guard < 32) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("pre_reset_div_cnt", {28'd0, dut.div_cnt}, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_run", run, 0);
    checkOutput("async_reset_tick", tick, 0);
    checkOutput("async_reset_div_cnt", {28'd0, dut.div_cnt}, 0);
    checkOutput("async_reset_db_cnt", {28'd0, dut.db_cnt}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitRun(1'b1, 40, n);
    checkOutput("reset_recover_edges", n, DB + 3);
    @(negedge clk);

    for (int s = 0; s < 150; s++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end
    applyStimulus(1'b0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_input_conditioner.md
# counter_input_conditioner

- Upstream stage of the 8-LED ripple counter.
- Synchronises and debounces the raw `SW` slide switch, then produces:
  - a debounced run level `run`,
  - a slow, evenly spaced one-cycle pulse `tick` that clocks the counter's first stage.
- Outputs change only on `clk` edges, so the LED counter sees a clean step per tick instead of the raw board clock.

## Interface
- Parameters:
  - `DIV`, default 25_000_000: tick period in `clk` cycles; legal range ≥ 2.
  - `DB_CYCLES`, default 1_000_000: number of consecutive stable synchronised cycles needed to accept a switch change; legal range ≥ 1.
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Ports:
  - `clk` input 1: system clock; all state updates on its rising edge.
  - `rst_n` input 1: asynchronous active-low reset.
  - `SW` input 1: raw, asynchronous, bouncing slide switch.
  - `run` output 1: debounced switch level; 1 = counting enabled.
  - `tick` output 1: one-cycle pulse every `DIV` cycles while `run`=1.
  - `sw_rise` output 1: one-cycle pulse on the cycle after `run` goes 0→1.
  - `sw_fall` output 1: one-cycle pulse on the cycle after `run` goes 1→0.

## Operation
- Reset values (all registered):
  - `run`=0, `tick`=0, `sw_rise`=0, `sw_fall`=0.
  - Synchroniser flops 0, FSM in STABLE_LO, `db_cnt`=0, `div_cnt`=0.
- Synchroniser:
  - Two flops: `SW` → `s1` → `sw_s`.
  - Only `sw_s` is used downstream.
- Debounce FSM, 4 states:
  - STABLE_LO (`run`=0): `sw_s`=1 → CHK_HI, `db_cnt`←0.
  - CHK_HI: `sw_s`=0 → STABLE_LO. Otherwise, if `db_cnt`==DB_CYCLES-1 → STABLE_HI with `run`←1; else `db_cnt`++.
  - STABLE_HI (`run`=1): `sw_s`=0 → CHK_LO, `db_cnt`←0.
  - CHK_LO: mirror of CHK_HI. Return to STABLE_HI on `sw_s`=1; enter STABLE_LO with `run`←0 on count expiry.
  - A glitch shorter than `DB_CYCLES` synchronised cycles never changes `run`. Any reversal restarts the count from 0.
- `db_cnt` width: `$clog2(DB_CYCLES)` bits, minimum 1. It never exceeds DB_CYCLES-1.
- Edge pulses:
  - `sw_rise` ← `run_next` & ~`run`; `sw_fall` ← ~`run_next` & `run`.
  - Each is high for exactly one cycle; they are never both high.
- Prescaler:
  - `div_cnt` width: `$clog2(DIV)` bits.
  - If `run`=0: `div_cnt`←0 and `tick`←0.
  - Else if `div_cnt`==DIV-1: `div_cnt`←0 and `tick`←1.
  - Else: `div_cnt`++ and `tick`←0.
  - All decisions use the pre-edge value of `run`.
- Simultaneous events: `run` falls at edge F while `div_cnt`==DIV-1 (pre-edge `run`=1) → `tick` still fires at F. From F+1 onward, no tick and `div_cnt`=0.
- Reset mid-operation: all outputs clear immediately and asynchronously. After release, behaviour is as from power-up: `SW` held high gives `run` rising 2+DB_CYCLES edges after the first edge at which `rst_n`=1.

## Timing
- Raw `SW` stable high before edge k:
  - `s1`=1 at k; `sw_s`=1 at k+1.
  - FSM enters CHK_HI at k+2.
  - `run`=1 after edge k+2+DB_CYCLES.
  - `sw_rise` is high during the cycle after that edge.
- The falling path has identical latency.
- `run` rises at edge R:
  - First `tick` after edge R+DIV.
  - Subsequent ticks every `DIV` edges.
  - Duty: 1 cycle high, DIV-1 low.
- No combinational path from `SW` to any output.

## Structure
- Shared package `counter_pkg`:
  - enum `db_state_t` {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO}.
  - Default constants `DIV_DEFAULT` and `DB_CYCLES_DEFAULT`.
- One sub-module, `sync_2ff`: parameter-free 2-flop synchroniser with async active-low reset to 0. It is reused for any future board input.
- Debounce FSM and prescaler stay in the top module.

## Test plan
All scenarios use DIV=8, DB_CYCLES=4.
- Reset: hold `rst_n`=0 with `SW`=1 → all outputs 0. Release before edge 0 → `run`=1 after edge 6, `sw_rise` high for 1 cycle, first `tick` after edge 14.
- Bounce rejection: `SW` high for 3 cycles, low 2, high 3, then low → `run` stays 0 throughout; no `sw_rise`.
- Steady tick: `SW` held high for 100 cycles after `run`=1 → `tick` pulses exactly every 8 cycles, 1 cycle wide, 12 pulses in 96 cycles.
- Wrap collision: drop `SW` timed so that `run` falls at the edge where `div_cnt`=7 → one final `tick` at that edge; none after; `sw_fall` high for 1 cycle; `div_cnt`=0.
- Mid-run reset: assert `rst_n`=0 asynchronously mid-cycle while `div_cnt`=5 and `run`=1 → `run`, `tick` and counters 0 immediately. Release with `SW`=1 → `run` back to 1 after 6 edges.
- Fall latency: `run`=1, `SW`→0 before edge k → `run`=0 after edge k+6; no tick after edge k+6.
